fp_hazard_ctrl: RTL and testbench

FP_HAZARD_CTRL -- requirements
Module: fp_hazard_ctrl

---
 rtl/fp_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_fp_hazard_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fp_hazard_ctrl.sv
// fp_hazard_ctrl: issue/hazard controller for an in-order pipelined FPU with writeback and optional bypass.
//
// Tracks up to DEPTH in-flight FPU ops in an in-order FIFO of {rd, rd_we}. It stalls issue on
// RAW/WAW hits against pending destinations or on a full FIFO, and steers FPU results to the
// FP register file. A flush drains the in-flight ops and discards their results.
//
// Optional feature macro: FP_HAZARD_BYPASS_EN. When it is defined, a RAW hit on only the
// completing head op is forwarded from fpu_result_i instead of stalling.
//
// Ports:
//   clk_i, rst_ni                    clock; asynchronous active-low reset
//   id_valid_i                       FP instruction presented for issue
//   rs1_i/rs2_i/rs3_i, use_rs*_i     source addresses and their read enables
//   rd_i, rd_we_i                    destination address and write enable
//   flush_i                          kill all in-flight ops
//   fpu_valid_o, fpu_ready_i         issue handshake to the FPU
//   fpu_done_i, fpu_result_i         in-order completion of the oldest op and its result
//   stall_o                          hold the issuing stage
//   byp_sel_a/b/c_o, byp_data_o      per-source bypass select and bypass data
//   wb_we_o, wb_addr_o, wb_data_o    FP register-file write port
//   err_o                            sticky flag for a done with nothing in flight
module fp_hazard_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        id_valid_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rs3_i,
    input  logic        use_rs1_i,
    input  logic        use_rs2_i,
    input  logic        use_rs3_i,
    input  logic [4:0]  rd_i,
    input  logic        rd_we_i,
    input  logic        flush_i,
    output logic        fpu_valid_o,
    input  logic        fpu_ready_i,
    input  logic        fpu_done_i,
    input  logic [31:0] fpu_result_i,
    output logic        stall_o,
    output logic        byp_sel_a_o,
    output logic        byp_sel_b_o,
    output logic        byp_sel_c_o,
    output logic [31:0] byp_data_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [4:0]       rd_q [DEPTH];
    logic [DEPTH-1:0] we_q;
    logic [AW-1:0]    head_q, tail_q;
    logic [AW:0]      count_q, count_d;
    logic             err_q;
    logic [DEPTH-1:0] live, hit1, hit2, hit3, hitw;
    logic             run, head_done, full, raw1, raw2, raw3, byp1, byp2, byp3, hazard, issue;

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        live = '0;
        hit1 = '0;
        hit2 = '0;
        hit3 = '0;
        hitw = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = {1'b0, AW'(i) - head_q} < count_q;
            hit1[i] = live[i] & we_q[i] & (rd_q[i] == rs1_i);
            hit2[i] = live[i] & we_q[i] & (rd_q[i] == rs2_i);
            hit3[i] = live[i] & we_q[i] & (rd_q[i] == rs3_i);
            hitw[i] = live[i] & we_q[i] & (rd_q[i] == rd_i);
        end
    end

    assign run       = (state_q == RUN);
    assign head_done = fpu_done_i & (count_q != '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign raw1      = use_rs1_i & |hit1;
    assign raw2      = use_rs2_i & |hit2;
    assign raw3      = use_rs3_i & |hit3;

`ifdef FP_HAZARD_BYPASS_EN
    logic [DEPTH-1:0] head_oh;

    always_comb begin
        head_oh = '0;
        for (int i = 0; i < DEPTH; i++) head_oh[i] = (AW'(i) == head_q);
    end

    // Forward only when the completing head is the sole match, so it is also the youngest writer.
    assign byp1 = use_rs1_i & (hit1 == head_oh) & head_done & run;
    assign byp2 = use_rs2_i & (hit2 == head_oh) & head_done & run;
    assign byp3 = use_rs3_i & (hit3 == head_oh) & head_done & run;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
    assign byp3 = 1'b0;
`endif

    // A full FIFO stalls even when the head retires this cycle, keeping fpu_valid_o off the done path.
    assign hazard = (raw1 & ~byp1) | (raw2 & ~byp2) | (raw3 & ~byp3) | (rd_we_i & |hitw) | full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (issue) tail_q <= tail_q + 1'b1;
            if (head_done) head_q <= head_q + 1'b1;
            if (fpu_done_i && count_q == '0) err_q <= 1'b1;
        end
    end

    // Payload needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            rd_q[tail_q] <= rd_i;
            we_q[tail_q] <= rd_we_i;
        end
    end

    // Flush leaves for DRAIN only if something is still in flight after this cycle's pop.
    always_comb begin
        count_d = count_q + (AW+1)'(issue) - (AW+1)'(head_done);
        state_d = run ? ((flush_i && count_d != '0) ? DRAIN : RUN) : ((count_d == '0) ? RUN : DRAIN);
    end

    // Outputs are forced low while reset is asserted, including the data buses.
    always_comb begin
        fpu_valid_o = rst_ni & id_valid_i & ~hazard & run & ~flush_i;
        issue       = fpu_valid_o & fpu_ready_i;
        stall_o     = rst_ni & id_valid_i & ~issue;
        wb_we_o     = rst_ni & head_done & we_q[head_q] & run;
        wb_addr_o   = rst_ni ? rd_q[head_q] : 5'd0;
        wb_data_o   = rst_ni ? fpu_result_i : 32'd0;
        byp_sel_a_o = rst_ni & byp1;
        byp_sel_b_o = rst_ni & byp2;
        byp_sel_c_o = rst_ni & byp3;
`ifdef FP_HAZARD_BYPASS_EN
        byp_data_o  = rst_ni ? fpu_result_i : 32'd0;
`else
        byp_data_o  = 32'd0;
`endif
        err_o       = err_q;
    end
endmodule

// File: tb/tb_fp_hazard_ctrl.sv
// tb_fp_hazard_ctrl: directed scoreboard bench for fp_hazard_ctrl.
module tb_fp_hazard_ctrl;
`ifdef FP_HAZARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        id_valid_i = 1'b0, use_rs1_i = 1'b0, use_rs2_i = 1'b0, use_rs3_i = 1'b0;
    logic [4:0]  rs1_i = '0, rs2_i = '0, rs3_i = '0, rd_i = '0;
    logic        rd_we_i = 1'b0, flush_i = 1'b0, fpu_ready_i = 1'b0, fpu_done_i = 1'b0;
    logic [31:0] fpu_result_i = '0;
    logic        fpu_valid_o, stall_o, byp_sel_a_o, byp_sel_b_o, byp_sel_c_o, wb_we_o, err_o;
    logic [31:0] byp_data_o, wb_data_o;
    logic [4:0]  wb_addr_o;

    fp_hazard_ctrl #(.DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i),
        .use_rs1_i(use_rs1_i), .use_rs2_i(use_rs2_i), .use_rs3_i(use_rs3_i),
        .rd_i(rd_i), .rd_we_i(rd_we_i), .flush_i(flush_i),
        .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_done_i(fpu_done_i),
        .fpu_result_i(fpu_result_i), .stall_o(stall_o),
        .byp_sel_a_o(byp_sel_a_o), .byp_sel_b_o(byp_sel_b_o), .byp_sel_c_o(byp_sel_c_o),
        .byp_data_o(byp_data_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
        .wb_data_o(wb_data_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string      nm;
        bit         st, fv, wb, er, rz;
        logic [4:0] wa;
        logic [2:0] bs;
        logic [31:0] d;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;
    bit err_exp = 1'b0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, req);
        end
    endtask

    // Monitor: every cycle with an expectation queued, pop and compare mid-cycle.
    always @(negedge clk_i) begin
        if (q.size() > 0) begin
            exp_t r;
            r = q.pop_front();
            chk({r.nm, ".stall"}, 32'(stall_o), 32'(r.st));
            chk({r.nm, ".fpu_valid"}, 32'(fpu_valid_o), 32'(r.fv));
            chk({r.nm, ".wb_we"}, 32'(wb_we_o), 32'(r.wb));
            chk({r.nm, ".byp_sel"}, 32'({byp_sel_c_o, byp_sel_b_o, byp_sel_a_o}), 32'(r.bs));
            chk({r.nm, ".err"}, 32'(err_o), 32'(r.er));
            if (r.wb) begin
                chk({r.nm, ".wb_addr"}, 32'(wb_addr_o), 32'(r.wa));
                chk({r.nm, ".wb_data"}, wb_data_o, r.d);
            end
            if (r.bs != 3'b000) chk({r.nm, ".byp_data"}, byp_data_o, r.d);
            if (r.rz) begin
                chk({r.nm, ".rst_wb_data"}, wb_data_o, 32'd0);
                chk({r.nm, ".rst_wb_addr"}, 32'(wb_addr_o), 32'd0);
                chk({r.nm, ".rst_byp_data"}, byp_data_o, 32'd0);
            end
        end
    end

    task automatic cyc(input string nm, input bit idv, input logic [2:0] u,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3,
                       input logic [4:0] rd, input bit we, input bit fl, input bit rdy,
                       input bit dn, input logic [31:0] res,
                       input bit e_st, input bit e_fv, input bit e_wb,
                       input logic [4:0] e_wa, input logic [2:0] e_bs);
        exp_t r;
        id_valid_i = idv;
        {use_rs3_i, use_rs2_i, use_rs1_i} = u;
        rs1_i = s1; rs2_i = s2; rs3_i = s3;
        rd_i = rd; rd_we_i = we; flush_i = fl;
        fpu_ready_i = rdy; fpu_done_i = dn; fpu_result_i = res;
        r.nm = nm; r.st = e_st; r.fv = e_fv; r.wb = e_wb; r.wa = e_wa; r.bs = e_bs;
        r.d = res; r.er = err_exp; r.rz = ~rst_ni;
        q.push_back(r);
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue_op(input string nm, input logic [4:0] rd);
        cyc(nm, 1, 3'b000, 0, 0, 0, rd, 1, 0, 1, 0, 32'd0, 0, 1, 0, 5'd0, 3'b000);
    endtask

    task automatic done_op(input string nm, input logic [31:0] res, input bit e_wb, input logic [4:0] e_wa);
        cyc(nm, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1, res, 0, 0, e_wb, e_wa, 3'b000);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk_i);
        #1;
        cyc("rst0", 1, 3'b111, 3, 3, 3, 3, 1, 0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 3'b000);
        cyc("rst1", 1, 3'b111, 3, 3, 3, 3, 1, 0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 3'b000);
        rst_ni = 1'b1;
        cyc("idle", 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 32'd0, 0, 0, 0, 0, 3'b000);
        // RAW on a busy FPU, resolved (or not) when the head completes
        issue_op("raw_iss", 3);
        cyc("raw_stall", 1, 3'b001, 3, 0, 0, 7, 1, 0, 1, 0, 32'd0, 1, 0, 0, 0, 3'b000);
        cyc("raw_hold", 1, 3'b001, 3, 0, 0, 7, 1, 0, 1, 0, 32'd0, 1, 0, 0, 0, 3'b000);
        cyc("raw_done", 1, 3'b001, 3, 0, 0, 7, 1, 0, 1, 1, 32'h40000000, !BYP, BYP, 1, 3, BYP ? 3'b001 : 3'b000);
`ifndef FP_HAZARD_BYPASS_EN
        cyc("raw_retry", 1, 3'b001, 3, 0, 0, 7, 1, 0, 1, 0, 32'd0, 0, 1, 0, 0, 3'b000);
`endif
        done_op("raw_ret7", 32'h11, 1, 7);
        // bypass on source b with the classic 1.0f result
        issue_op("byp_iss", 3);
        cyc("byp_b", 1, 3'b010, 0, 3, 0, 8, 1, 0, 1, 1, 32'h3F800000, !BYP, BYP, 1, 3, BYP ? 3'b010 : 3'b000);
`ifndef FP_HAZARD_BYPASS_EN
        cyc("byp_b_retry", 1, 3'b010, 0, 3, 0, 8, 1, 0, 1, 0, 32'd0, 0, 1, 0, 0, 3'b000);
`endif
        done_op("byp_ret8", 32'h22, 1, 8);
        // RAW on a non-head entry is never forwarded; then source c once it becomes head
        issue_op("nh_iss1", 1);
        issue_op("nh_iss2", 2);
        cyc("nh_stall", 1, 3'b100, 0, 0, 2, 9, 0, 0, 1, 1, 32'h33, 1, 0, 1, 1, 3'b000);
        cyc("byp_c", 1, 3'b100, 0, 0, 2, 9, 0, 0, 1, 1, 32'h44, !BYP, BYP, 1, 2, BYP ? 3'b100 : 3'b000);
`ifndef FP_HAZARD_BYPASS_EN
        cyc("byp_c_retry", 1, 3'b100, 0, 0, 2, 9, 0, 0, 1, 0, 32'd0, 0, 1, 0, 0, 3'b000);
`endif
        done_op("nh_ret_nowe", 32'h55, 0, 0);
        // WAW with unused sources that alias the pending rd
        issue_op("waw_iss", 5);
        cyc("waw_stall", 1, 3'b000, 5, 5, 5, 5, 1, 0, 1, 0, 32'd0, 1, 0, 0, 0, 3'b000);
        cyc("waw_done", 1, 3'b000, 5, 5, 5, 5, 1, 0, 1, 1, 32'h66, 1, 0, 1, 5, 3'b000);
        cyc("waw_iss2", 1, 3'b000, 5, 5, 5, 5, 1, 0, 1, 0, 32'd0, 0, 1, 0, 0, 3'b000);
        cyc("waw_nowe", 1, 3'b000, 0, 0, 0, 5, 0, 0, 1, 0, 32'd0, 0, 1, 0, 0, 3'b000);
        done_op("waw_ret5", 32'h77, 1, 5);
        done_op("waw_ret_nowe", 32'h88, 0, 0);
        cyc("rdy_low", 1, 3'b000, 0, 0, 0, 4, 1, 0, 0, 0, 32'd0, 1, 1, 0, 0, 3'b000);
        // full FIFO stalls even with a same-cycle completion
        issue_op("full_iss10", 10);
        issue_op("full_iss11", 11);
        issue_op("full_iss12", 12);
        issue_op("full_iss13", 13);
        cyc("full_stall", 1, 3'b000, 0, 0, 0, 14, 1, 0, 1, 0, 32'd0, 1, 0, 0, 0, 3'b000);
        cyc("full_done", 1, 3'b000, 0, 0, 0, 14, 1, 0, 1, 1, 32'h99, 1, 0, 1, 10, 3'b000);
        cyc("full_iss14", 1, 3'b000, 0, 0, 0, 14, 1, 0, 1, 0, 32'd0, 0, 1, 0, 0, 3'b000);
        done_op("full_ret11", 32'hA1, 1, 11);
        done_op("full_ret12", 32'hA2, 1, 12);
        done_op("full_ret13", 32'hA3, 1, 13);
        done_op("full_ret14", 32'hA4, 1, 14);
        // flush: empty flush stays in RUN, loaded flush drains with results discarded
        cyc("fl_empty", 1, 3'b000, 0, 0, 0, 1, 1, 1, 1, 0, 32'd0, 1, 0, 0, 0, 3'b000);
        issue_op("fl_iss20", 20);
        issue_op("fl_iss21", 21);
        issue_op("fl_iss22", 22);
        cyc("fl_go", 1, 3'b000, 0, 0, 0, 1, 1, 1, 1, 0, 32'd0, 1, 0, 0, 0, 3'b000);
        cyc("drain1", 1, 3'b000, 0, 0, 0, 1, 1, 0, 1, 1, 32'hB1, 1, 0, 0, 0, 3'b000);
        cyc("drain2", 1, 3'b000, 0, 0, 0, 1, 1, 0, 1, 1, 32'hB2, 1, 0, 0, 0, 3'b000);
        cyc("drain3", 1, 3'b000, 0, 0, 0, 1, 1, 0, 1, 1, 32'hB3, 1, 0, 0, 0, 3'b000);
        cyc("fl_resume", 1, 3'b000, 0, 0, 0, 1, 1, 0, 1, 0, 32'd0, 0, 1, 0, 0, 3'b000);
        done_op("fl_ret1", 32'hC1, 1, 1);
        // reset mid-operation discards in-flight entries
        issue_op("mr_iss6", 6);
        issue_op("mr_iss7", 7);
        rst_ni = 1'b0;
        cyc("mr_rst", 1, 3'b000, 0, 0, 0, 8, 1, 0, 1, 1, 32'h0000DEAD, 0, 0, 0, 0, 3'b000);
        rst_ni = 1'b1;
        // spurious done sets a sticky error and leaves count at zero
        done_op("spur", 32'hE1, 0, 0);
        err_exp = 1'b1;
        cyc("spur_sticky", 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 32'd0, 0, 0, 0, 0, 3'b000);
        issue_op("spur_iss9", 9);
        done_op("spur_ret9", 32'hF1, 1, 9);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
